// File: rtl/cpu6502_pkg.sv
// Shared types and constants for the cpu6502_core_lite slice.
// CPU6502_ZPG_EN adds the zero-page states and opcodes.
package cpu6502_pkg;

    typedef enum logic [3:0] {
        ST_RST0, ST_RST1, ST_FETCH, ST_IMM,
`ifdef CPU6502_ZPG_EN
        ST_ZPA, ST_ZPR, ST_ZPW,
`endif
        ST_IMPL, ST_JLO, ST_JHI, ST_HALT
    } state_t;

    typedef enum logic [1:0] {ALU_PASS, ALU_INC, ALU_DEC} alu_op_t;
    typedef enum logic [1:0] {DST_NONE, DST_A, DST_X, DST_Y} dst_t;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9, OP_LDX_IMM = 8'hA2, OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_LDA_ZP  = 8'hA5, OP_LDX_ZP  = 8'hA6, OP_LDY_ZP  = 8'hA4;
    localparam logic [7:0] OP_STA_ZP  = 8'h85, OP_STX_ZP  = 8'h86, OP_STY_ZP  = 8'h84;
    localparam logic [7:0] OP_TAX = 8'hAA, OP_TXA = 8'h8A, OP_INX = 8'hE8, OP_INY = 8'hC8;
    localparam logic [7:0] OP_DEX = 8'hCA, OP_DEY = 8'h88, OP_NOP = 8'hEA, OP_JMP = 8'h4C;

    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    function automatic state_t decode(input logic [7:0] op);
        case (op)
            OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM: return ST_IMM;
`ifdef CPU6502_ZPG_EN
            OP_LDA_ZP, OP_LDX_ZP, OP_LDY_ZP,
            OP_STA_ZP, OP_STX_ZP, OP_STY_ZP:    return ST_ZPA;
`endif
            OP_TAX, OP_TXA, OP_INX, OP_INY,
            OP_DEX, OP_DEY, OP_NOP:             return ST_IMPL;
            OP_JMP:                             return ST_JLO;
            default:                            return ST_HALT;
        endcase
    endfunction

endpackage

// File: rtl/cpu6502_core_lite_if.sv
// System bus between the core (master) and the flat 64 KiB memory (slave).
interface cpu6502_core_lite_if;
    logic [15:0] ab;
    logic [7:0]  di;
    logic [7:0]  dout;
    logic        we;
    logic        rdy;

    modport master (output ab, dout, we, input di, rdy);
    modport slave  (input ab, dout, we, output di, rdy);
endinterface

// File: rtl/cpu6502_alu.sv
// Combinational pass/increment/decrement unit with N/Z outputs.
module cpu6502_alu
    import cpu6502_pkg::*;
(
    input  logic [7:0] operand,
    input  alu_op_t    op,
    output logic [7:0] result,
    output logic       n,
    output logic       z
);
    always_comb begin
        result = operand;
        case (op)
            ALU_INC: result = operand + 8'd1;
            ALU_DEC: result = operand - 8'd1;
            default: result = operand;
        endcase
    end

    assign n = result[7];
    assign z = (result == 8'h00);
endmodule

// File: rtl/cpu6502_core_lite.sv
// Multi-cycle 6502 subset core: reset vector, loads/stores, transfers, inc/dec, JMP.
// CPU6502_ZPG_EN enables zero-page load/store; without it those opcodes halt.
module cpu6502_core_lite
    import cpu6502_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic                        clk,
    input  logic                        reset,
    cpu6502_core_lite_if.master         bus,
    output logic                        sync,
    output logic                        halt,
    output logic [7:0]                  a_q,
    output logic [7:0]                  x_q,
    output logic [7:0]                  y_q,
    output logic [1:0]                  flags_q
);
    state_t      state;
    logic [15:0] pc;
    logic [7:0]  ir, lo, a, x, y;
    logic [1:0]  flags;
`ifdef CPU6502_ZPG_EN
    logic [7:0]  zp;
`endif

    logic [7:0] alu_in, alu_res;
    alu_op_t    alu_op;
    logic       alu_n, alu_z;
    dst_t       dst;
    logic       advance;

    // Writes never stall, so a held rdy only freezes read cycles.
    assign advance = bus.rdy | bus.we;

    always_comb begin
        bus.ab   = pc;
        bus.we   = 1'b0;
        bus.dout = 8'h00;
        sync     = 1'b0;
        halt     = 1'b0;
        case (state)
            ST_RST0:  bus.ab = RESET_VECTOR;
            ST_RST1:  bus.ab = RESET_VECTOR + 16'd1;
            ST_FETCH: sync   = 1'b1;
`ifdef CPU6502_ZPG_EN
            ST_ZPR:   bus.ab = {8'h00, zp};
            ST_ZPW: begin
                bus.ab = {8'h00, zp};
                bus.we = 1'b1;
                case (ir)
                    OP_STX_ZP: bus.dout = x;
                    OP_STY_ZP: bus.dout = y;
                    default:   bus.dout = a;
                endcase
            end
`endif
            ST_HALT:  halt = 1'b1;
            default:  ;
        endcase
    end

    // Loads pass di through; implied ops pick their source register from ir.
    always_comb begin
        alu_in = bus.di;
        alu_op = ALU_PASS;
        if (state == ST_IMPL) begin
            case (ir)
                OP_TXA:  alu_in = x;
                OP_INX:  begin alu_in = x; alu_op = ALU_INC; end
                OP_DEX:  begin alu_in = x; alu_op = ALU_DEC; end
                OP_INY:  begin alu_in = y; alu_op = ALU_INC; end
                OP_DEY:  begin alu_in = y; alu_op = ALU_DEC; end
                default: alu_in = a;
            endcase
        end
        case (ir)
            OP_LDA_IMM, OP_LDA_ZP, OP_TXA:                  dst = DST_A;
            OP_LDX_IMM, OP_LDX_ZP, OP_TAX, OP_INX, OP_DEX:  dst = DST_X;
            OP_LDY_IMM, OP_LDY_ZP, OP_INY, OP_DEY:          dst = DST_Y;
            default:                                        dst = DST_NONE;
        endcase
    end

    cpu6502_alu u_alu (
        .operand (alu_in),
        .op      (alu_op),
        .result  (alu_res),
        .n       (alu_n),
        .z       (alu_z)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RST0;
            pc    <= 16'h0000;
            ir    <= 8'h00;
            lo    <= 8'h00;
            a     <= 8'h00;
            x     <= 8'h00;
            y     <= 8'h00;
            flags <= 2'b00;
`ifdef CPU6502_ZPG_EN
            zp    <= 8'h00;
`endif
        end else if (advance) begin
            // IMM, ZPR and IMPL all retire through the ALU into dst.
            if (state == ST_IMM || state == ST_IMPL
`ifdef CPU6502_ZPG_EN
                || state == ST_ZPR
`endif
               ) begin
                case (dst)
                    DST_A:   a <= alu_res;
                    DST_X:   x <= alu_res;
                    DST_Y:   y <= alu_res;
                    default: ;
                endcase
                if (dst != DST_NONE) begin
                    flags[FLAG_N] <= alu_n;
                    flags[FLAG_Z] <= alu_z;
                end
            end
            case (state)
                ST_RST0: begin lo <= bus.di; state <= ST_RST1; end
                ST_RST1: begin pc <= {bus.di, lo}; state <= ST_FETCH; end
                ST_FETCH: begin
                    ir    <= bus.di;
                    pc    <= pc + 16'd1;
                    state <= decode(bus.di);
                end
                ST_IMM:  begin pc <= pc + 16'd1; state <= ST_FETCH; end
`ifdef CPU6502_ZPG_EN
                ST_ZPA: begin
                    zp    <= bus.di;
                    pc    <= pc + 16'd1;
                    state <= (ir == OP_STA_ZP || ir == OP_STX_ZP || ir == OP_STY_ZP)
                             ? ST_ZPW : ST_ZPR;
                end
                ST_ZPR:  state <= ST_FETCH;
                ST_ZPW:  state <= ST_FETCH;
`endif
                ST_IMPL: state <= ST_FETCH;
                ST_JLO:  begin lo <= bus.di; pc <= pc + 16'd1; state <= ST_JHI; end
                ST_JHI:  begin pc <= {bus.di, lo}; state <= ST_FETCH; end
                default: state <= ST_HALT;
            endcase
        end
    end

    assign a_q     = a;
    assign x_q     = x;
    assign y_q     = y;
    assign flags_q = flags;
endmodule
